wallace_accumulator: RTL and testbench

WALLACE_ACCUMULATOR -- requirements
Module: wallace_accumulator

---
 rtl/wallace_pkg.sv | 12 +
 rtl/wallaceAdder.sv | 18 +
 rtl/wallace_accumulator.sv | 122 ++++++++++++
 tb/tb_wallace_accumulator.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared widths and FSM encoding for the frame accumulator and its 3-operand adder.
package wallace_pkg;
    localparam int OPERAND_W = 4;
    localparam int ADDER_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/wallaceAdder.sv
// Combinational 3-operand adder: one carry-save layer compresses A, B and C to two rows,
// then a single carry-propagate add; zero latency, no flow control.
module wallaceAdder
    import wallace_pkg::*;
(
    input  logic [OPERAND_W-1:0] A,
    input  logic [OPERAND_W-1:0] B,
    input  logic [OPERAND_W-1:0] C,
    output logic [ADDER_W-1:0]   S
);
    logic [OPERAND_W-1:0] w_sum_row;
    logic [OPERAND_W-1:0] w_carry_row;

    assign w_sum_row   = A ^ B ^ C;
    assign w_carry_row = (A & B) | (A & C) | (B & C);
    // Carry row carries weight 2, hence the one-bit left shift.
    assign S = {2'b00, w_sum_row} + {1'b0, w_carry_row, 1'b0};
endmodule

// File: rtl/wallace_accumulator.sv
// Sums A+B+C over a frame of up to FRAME_LEN beats; result valid 2 cycles after the last accept.
// in_ready drops from the last accept until the result is taken; the result holds while out_ready=0.
module wallace_accumulator
    import wallace_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [OPERAND_W-1:0] A,
    input  logic [OPERAND_W-1:0] B,
    input  logic [OPERAND_W-1:0] C,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     SUM,
    output logic [3:0]           NBEATS,
    output logic                 OVF
);
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDER_W-1:0]  w_beat_sum;
    logic                w_accept;
    logic                w_last;
    logic                w_clear;
    logic                r_s1_vld;
    logic                r_s1_last;
    logic [ADDER_W-1:0]  r_s1_dat;
    logic [ACC_W-1:0]    r_acc;
    logic [3:0]          r_cnt;
    logic                r_ovf;
    logic [ACC_W:0]      w_acc_nxt;

    wallaceAdder u_adder (
        .A (A),
        .B (B),
        .C (C),
        .S (w_beat_sum)
    );

    assign w_accept  = in_valid & in_ready;
    assign w_last    = in_last | (r_cnt == LAST_IDX);
    assign w_clear   = out_valid & out_ready;
    assign w_acc_nxt = {1'b0, r_acc} + {{(ACC_W + 1 - ADDER_W){1'b0}}, r_s1_dat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_last ? ST_FLUSH : ST_ACCUM;
            ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_FLUSH;
            // The closing beat sits in stage 1 here and lands in the accumulator on this edge.
            ST_FLUSH: if (r_s1_vld && r_s1_last) w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE:  in_ready  = 1'b1;
            ST_ACCUM: in_ready  = 1'b1;
            ST_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_dat  <= '0;
        end else begin
            r_s1_vld  <= w_accept;
            r_s1_last <= w_accept & w_last;
            if (w_accept) begin
                r_s1_dat <= w_beat_sum;
            end
        end
    end

    // Stage 1 is never valid in DONE, so the reported result cannot move while it waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (r_s1_vld) begin
                r_acc <= w_acc_nxt[ACC_W-1:0];
                if (w_acc_nxt[ACC_W]) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_accept) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign SUM    = r_acc;
    assign NBEATS = r_cnt;
    assign OVF    = r_ovf;
endmodule

// File: tb/tb_wallace_accumulator.sv
// Directed bench: two instances (FRAME_LEN=4 and FRAME_LEN=8) share stimulus, selected by sel.
module tb_wallace_accumulator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0, b = '0, c = '0;
    logic       last = 1'b0;
    logic       vld = 1'b0;
    logic       ordy = 1'b0;
    logic       sel = 1'b0;

    logic       rdy4, ov4, ovf4, rdy8, ov8, ovf8;
    logic [7:0] sum4, sum8;
    logic [3:0] nb4, nb8;
    logic       rdy, ov, ovf;
    logic [7:0] sum;
    logic [3:0] nb;

    int n_chk = 0;
    int n_pass = 0;
    int waited;

    always #5 clk = ~clk;

    wallace_accumulator #(.FRAME_LEN(4), .ACC_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld & ~sel), .in_ready(rdy4), .in_last(last),
        .A(a), .B(b), .C(c), .out_valid(ov4), .out_ready(ordy & ~sel),
        .SUM(sum4), .NBEATS(nb4), .OVF(ovf4)
    );

    wallace_accumulator #(.FRAME_LEN(8), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld & sel), .in_ready(rdy8), .in_last(last),
        .A(a), .B(b), .C(c), .out_valid(ov8), .out_ready(ordy & sel),
        .SUM(sum8), .NBEATS(nb8), .OVF(ovf8)
    );

    assign rdy = sel ? rdy8 : rdy4;
    assign ov  = sel ? ov8  : ov4;
    assign ovf = sel ? ovf8 : ovf4;
    assign sum = sel ? sum8 : sum4;
    assign nb  = sel ? nb8  : nb4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Present one beat and hold it until accepted; waited counts stall cycles.
    task automatic beat(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ic,
                        input logic il, output int nwait);
        a = ia; b = ib; c = ic; last = il; vld = 1'b1;
        nwait = 0;
        while (!rdy && nwait < 20) begin
            @(posedge clk); #1;
            nwait++;
        end
        if (!rdy) chk("beat_ready_timeout", 0, 1);
        @(posedge clk); #1;
        vld = 1'b0; last = 1'b0;
    endtask

    // Called right after the last accept edge: out_valid low now, high one edge later.
    task automatic expect_result(input logic [7:0] es, input logic [3:0] en, input logic eo);
        chk("out_valid_cycle1", ov, 0);
        @(posedge clk); #1;
        chk("out_valid_cycle2", ov, 1);
        chk("sum", sum, es);
        chk("nbeats", nb, en);
        chk("ovf", ovf, eo);
        chk("in_ready_done", rdy, 0);
    endtask

    task automatic handshake();
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk("out_valid_after_hs", ov, 0);
        chk("in_ready_after_hs", rdy, 1);
    endtask

    task automatic frame_88(input bit bubbles);
        logic [3:0] va [4] = '{4'd1, 4'd9, 4'd15, 4'd0};
        logic [3:0] vb [4] = '{4'd2, 4'd12, 4'd15, 4'd0};
        logic [3:0] vc [4] = '{4'd4, 4'd15, 4'd15, 4'd0};
        int w;
        for (int i = 0; i < 4; i++) begin
            if (bubbles) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            beat(va[i], vb[i], vc[i], 1'b0, w);
            if (!bubbles) chk("b2b_no_stall", w, 0);
        end
    endtask

    initial begin
        #1;
        chk("rst_out_valid", ov, 0);
        chk("rst_sum", sum, 0);
        chk("rst_nbeats", nb, 0);
        chk("rst_ovf", ovf, 0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", rdy, 1);

        // Back-to-back frame of four, then a 5-cycle stall on the result.
        frame_88(1'b0);
        expect_result(8'd88, 4'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", ov, 1);
            chk("stall_sum", sum, 88);
            chk("stall_nbeats", nb, 4);
            chk("stall_ovf", ovf, 0);
            chk("stall_in_ready", rdy, 0);
        end
        handshake();

        // Early close via in_last; first beat must go in on the cycle after the handshake.
        beat(4'd15, 4'd15, 4'd15, 1'b0, waited);
        chk("accept_after_hs", waited, 0);
        beat(4'd15, 4'd15, 4'd15, 1'b1, waited);
        expect_result(8'd90, 4'd2, 1'b0);
        handshake();

        // FRAME_LEN=8: 8*45=360 wraps to 104 with overflow, then a clean frame.
        sel = 1'b1;
        #1;
        chk("dut8_ready", rdy, 1);
        for (int i = 0; i < 8; i++) beat(4'd15, 4'd15, 4'd15, 1'b0, waited);
        expect_result(8'd104, 4'd8, 1'b1);
        handshake();
        for (int i = 0; i < 8; i++) beat(4'd1, 4'd0, 4'd0, 1'b0, waited);
        expect_result(8'd8, 4'd8, 1'b0);
        handshake();
        sel = 1'b0;
        #1;

        // Reset mid-frame: partial frame is dropped.
        beat(4'd3, 4'd3, 4'd3, 1'b0, waited);
        beat(4'd3, 4'd3, 4'd3, 1'b0, waited);
        chk("partial_sum_pre_rst", nb, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_nbeats", nb, 0);
        chk("midrst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("no_result_after_rst", ov, 0);
        end
        for (int i = 0; i < 4; i++) beat(4'd1, 4'd2, 4'd4, 1'b0, waited);
        expect_result(8'd28, 4'd4, 1'b0);
        handshake();

        // Same vectors as the first frame, with random one-cycle bubbles.
        frame_88(1'b1);
        expect_result(8'd88, 4'd4, 1'b0);
        handshake();
        frame_88(1'b1);
        expect_result(8'd88, 4'd4, 1'b0);
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
